serial_tx_arbiter: RTL and testbench
====================================

# serial_tx_arbiter

Shares the single on-board serial transmitter between up to N_REQ byte producers, for example switch capture, status reporter and echo path. Requesters are served round-robin. Each accepted byte is loaded into the transmitter with a one-cycle load strobe, and the block holds ownership until the transmitter's busy flag falls. An optional inter-frame gap, counted in baud ticks from the existing 9600 Hz divider chain, separates frames.

## Interface
- N_REQ, 4: number of requesters, 2..8.
- DATA_W, 8: byte width.
- GAP_TICKS, 2: baud ticks of idle line inserted after each frame; 0 means no gap.
- MAX_BURST, 4: maximum consecutive frames per owner while locked (lock feature only).
- clk  in  1  system clock (50 MHz domain).
- reset_n  in  1  asynchronous, active-low reset.
- baud_tick  in  1  one-clk pulse per bit period (9600 Hz).
- req  in  N_REQ  request per requester, level; must hold until granted.
- req_data  in  N_REQ*DATA_W  byte of requester i at [i*DATA_W +: DATA_W].
- req_lock  in  N_REQ  burst-lock request; ignored unless SERIAL_ARB_LOCK_EN.
- grant  out  N_REQ  one-hot, one-clk pulse; the byte is consumed.
- owner  out  N_REQ  one-hot, high from grant until gap end.
- tx_data  out  DATA_W  byte to transmitter, stable while owner≠0.
- tx_load  out  1  one-clk start strobe to transmitter.
- tx_busy  in  1  transmitter frame in progress.
- arb_busy  out  1  state≠IDLE.

## Operation
- States: IDLE, LOAD, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE: if req≠0, pick a winner round-robin starting at ptr. Latch the winner's req_data into tx_data, set owner, and go to LOAD.
- LOAD: grant[w] and tx_load are high for exactly this cycle. ptr←w+1 mod N_REQ. Next state is WAIT_BUSY.
- WAIT_BUSY: stay until tx_busy=1, then go to WAIT_DONE. tx_load is not re-issued.
- WAIT_DONE: stay until tx_busy=0. Then go to GAP if GAP_TICKS>0, else go to IDLE.
- GAP: count baud_tick pulses that occur strictly after GAP entry. At count GAP_TICKS, clear owner and go to IDLE.
- Gap counter width is clog2(GAP_TICKS+1). The counter saturates and never wraps.
- Dropping req after grant has no effect, because the data is already latched.
- Changing req_data of the owner mid-frame does not alter tx_data.
- A requester whose req is high in the same cycle as its grant is treated as a new request for the next arbitration. The bench holds req one cycle too long on purpose to exercise this.
- A tick coincident with the tx_busy fall (the WAIT_DONE→GAP edge) is not counted.
- Reset: state=IDLE, ptr=0, gap count=0, grant=0, owner=0, tx_data=0, tx_load=0, arb_busy=0. Reset mid-frame abandons the frame without a further tx_load.

## Timing
- req sampled high in IDLE at edge k → LOAD at k+1. grant and tx_load are high during cycle k+1.
- Best-case arbitration latency is 1 clk.
- Back-to-back frame spacing equals the transmitter frame time plus GAP_TICKS bit periods plus 2 clk (IDLE and LOAD).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- SERIAL_ARB_LOCK_EN defined:
  - At GAP exit, or at WAIT_DONE exit when GAP_TICKS=0, if the owner has req and req_lock high and its burst count < MAX_BURST, go directly to LOAD for the same owner. ptr is unchanged and the burst count increments.
  - The burst count resets on any owner change.
  - When MAX_BURST is reached, the next arbitration starts at owner+1.
- Not defined: req_lock is ignored, there is no burst counter, and every frame rearbitrates.

## Structure
- Package serial_arb_pkg holds:
  - the state enum `arb_state_t`;
  - the DATA_W default;
  - the N_REQ maximum.
- Sub-module rr_pick: combinational round-robin picker taking req and ptr and producing a one-hot winner plus a valid flag. It is reusable by other shared on-board resources.

## Test plan
- Single requester: req=0010, data 0x41, GAP_TICKS=2.
  - Expect grant=0010 and tx_load one cycle later, with tx_data=0x41.
  - owner clears exactly 2 ticks after tx_busy falls.
- All four requesting continuously with bytes 0xA0..0xA3:
  - grant order is 0,1,2,3,0. Each tx_load occurs only after the previous gap.
- req_data changed while in WAIT_DONE: tx_data holds the latched byte. No second tx_load before tx_busy falls.
- reset_n pulsed low during WAIT_DONE:
  - all outputs are 0 immediately, with no clock needed;
  - the next grant after reset goes to the lowest active index.
- With SERIAL_ARB_LOCK_EN and MAX_BURST=4: req1 locked while req2 pending → req1 gets 4 frames, then req2.
- Without SERIAL_ARB_LOCK_EN and the same stimulus: the two requesters alternate 1,2,1,2.

Source files
------------

// File: rtl/serial_arb_pkg.sv
// Shared types and limits for the serial transmitter arbiter.
// Used by serial_tx_arbiter (optional burst lock: SERIAL_ARB_LOCK_EN).
package serial_arb_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int N_REQ_MAX  = 8;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOAD      = 3'd1;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_GAP       = 3'd4;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        LOAD      = ST_LOAD,
        WAIT_BUSY = ST_WAIT_BUSY,
        WAIT_DONE = ST_WAIT_DONE,
        GAP       = ST_GAP
    } arb_state_t;

endpackage

// File: rtl/serial_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first active request at or after ptr.
// Reusable by any shared on-board resource.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic          valid
);

    int idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!valid && req[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Round-robin owner of the shared serial transmitter with gap timing.
// Define SERIAL_ARB_LOCK_EN to enable per-owner burst lock.
module serial_tx_arbiter
    import serial_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int GAP_TICKS = 2,
    parameter int MAX_BURST = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    baud_tick,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_lock,
    output logic [N_REQ-1:0]        grant,
    output logic [N_REQ-1:0]        owner,
    output logic [DATA_W-1:0]       tx_data,
    output logic                    tx_load,
    input  logic                    tx_busy,
    output logic                    arb_busy
);

    localparam int PW = $clog2(N_REQ_MAX);
    localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
    localparam logic [GW-1:0] GAP_LAST =
        GW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam logic [GW-1:0] GAP_MAX = GW'(GAP_TICKS);

    arb_state_t        state;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     own_idx;
    logic [PW-1:0]     nxt_ptr;
    logic [N_REQ-1:0]  pick;
    logic              pick_vld;
    logic [DATA_W-1:0] pick_data;
    logic [DATA_W-1:0] own_data;
    logic [GW-1:0]     gap_cnt;
    logic              frame_end;
    logic              relock;

    rr_pick #(
        .N  (N_REQ),
        .PW (PW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (pick),
        .valid  (pick_vld)
    );

    always_comb begin
        pick_data = '0;
        own_data  = '0;
        own_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick[i]) begin
                pick_data = req_data[i*DATA_W +: DATA_W];
            end
            if (owner[i]) begin
                own_data = req_data[i*DATA_W +: DATA_W];
                own_idx  = PW'(i);
            end
        end
    end

    assign nxt_ptr = (own_idx == PW'(N_REQ - 1)) ? '0 : own_idx + 1'b1;

    // Ticks are only counted once in GAP, so a tick on the busy fall is skipped
    assign frame_end =
        (state == WAIT_DONE && !tx_busy && GAP_TICKS == 0) ||
        (state == GAP && baud_tick && gap_cnt == GAP_LAST);

`ifdef SERIAL_ARB_LOCK_EN
    localparam int BW = $clog2(MAX_BURST + 1);

    logic [BW-1:0] burst;

    assign relock = frame_end &&
                    (|(owner & req & req_lock)) &&
                    (burst < BW'(MAX_BURST));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            burst <= '0;
        end else if (state == IDLE && pick_vld) begin
            burst <= BW'(1);
        end else if (relock) begin
            burst <= burst + 1'b1;
        end
    end
`else
    logic unused_lock;

    assign relock      = 1'b0;
    assign unused_lock = ^{req_lock, MAX_BURST[0]};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            ptr      <= '0;
            gap_cnt  <= '0;
            grant    <= '0;
            owner    <= '0;
            tx_data  <= '0;
            tx_load  <= 1'b0;
            arb_busy <= 1'b0;
        end else begin
            grant   <= '0;
            tx_load <= 1'b0;
            if (relock) begin
                state   <= LOAD;
                grant   <= owner;
                tx_load <= 1'b1;
                tx_data <= own_data;
            end else if (frame_end) begin
                state    <= IDLE;
                owner    <= '0;
                arb_busy <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (pick_vld) begin
                            state    <= LOAD;
                            grant    <= pick;
                            tx_load  <= 1'b1;
                            owner    <= pick;
                            tx_data  <= pick_data;
                            arb_busy <= 1'b1;
                        end
                    end
                    LOAD: begin
                        ptr   <= nxt_ptr;
                        state <= WAIT_BUSY;
                    end
                    WAIT_BUSY: begin
                        if (tx_busy) begin
                            state <= WAIT_DONE;
                        end
                    end
                    WAIT_DONE: begin
                        if (!tx_busy) begin
                            state   <= GAP;
                            gap_cnt <= '0;
                        end
                    end
                    GAP: begin
                        if (baud_tick && gap_cnt != GAP_MAX) begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Scoreboard bench for serial_tx_arbiter with a simple transmitter model.
// Expectations follow SERIAL_ARB_LOCK_EN when it is defined.
module tb_serial_tx_arbiter;

    localparam int N_REQ     = 4;
    localparam int DATA_W    = 8;
    localparam int GAP_TICKS = 2;
    localparam int MAX_BURST = 4;
    localparam int FRAME     = 30;

    typedef struct {
        int          idx;
        logic [7:0]  data;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        baud_tick;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_lock;
    logic [3:0]  grant;
    logic [3:0]  owner;
    logic [7:0]  tx_data;
    logic        tx_load;
    logic        tx_busy;
    logic        arb_busy;

    logic        auto_tx;
    logic        auto_busy;
    logic        man_busy;

    int   checks;
    int   errors;
    int   loads;
    int   ticks;
    logic prev_busy;
    logic have_frame;
    logic s_tick;
    logic s_busy;
    exp_t sb[$];
    exp_t e;

    assign tx_busy = auto_tx ? auto_busy : man_busy;

    serial_tx_arbiter #(
        .N_REQ     (N_REQ),
        .DATA_W    (DATA_W),
        .GAP_TICKS (GAP_TICKS),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .baud_tick (baud_tick),
        .req       (req),
        .req_data  (req_data),
        .req_lock  (req_lock),
        .grant     (grant),
        .owner     (owner),
        .tx_data   (tx_data),
        .tx_load   (tx_load),
        .tx_busy   (tx_busy),
        .arb_busy  (arb_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        baud_tick = 1'b0;
        forever begin
            repeat (7) @(negedge clk);
            baud_tick = 1'b1;
            @(negedge clk);
            baud_tick = 1'b0;
        end
    end

    initial begin
        auto_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (auto_tx && reset_n && tx_load) begin
                repeat (2) @(negedge clk);
                auto_busy = 1'b1;
                repeat (FRAME) @(negedge clk);
                auto_busy = 1'b0;
            end
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int idx, input logic [7:0] data);
        exp_t x;
        x.idx  = idx;
        x.data = data;
        sb.push_back(x);
    endtask

    // Scoreboard side: every tx_load pops one expected grant/byte
    initial begin
        loads      = 0;
        ticks      = 0;
        prev_busy  = 1'b0;
        have_frame = 1'b0;
        forever begin
            @(posedge clk);
            s_tick = baud_tick;
            s_busy = tx_busy;
            if (!reset_n) begin
                prev_busy  = 1'b0;
                ticks      = 0;
                have_frame = 1'b0;
            end else begin
                if (prev_busy && !s_busy) begin
                    ticks = 0;
                end else if (!s_busy && s_tick && ticks < 1000) begin
                    ticks++;
                end
                prev_busy = s_busy;
            end
            #1;
            if (reset_n && tx_load) begin
                loads++;
                if (have_frame) begin
                    chk("gap_before_load", 32'(ticks >= GAP_TICKS), 1);
                end
                have_frame = 1'b1;
                if (sb.size() == 0) begin
                    chk("unexpected_load", 32'(sb.size()), 1);
                end else begin
                    e = sb.pop_front();
                    chk("sb_grant", 32'(grant), 32'(1 << e.idx));
                    chk("sb_tx_data", 32'(tx_data), 32'(e.data));
                end
            end
        end
    end

    task automatic wait_load(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!tx_load && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(tx_load), 1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (arb_busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(arb_busy), 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int n;
        int nexp;
        checks   = 0;
        errors   = 0;
        reset_n  = 1'b0;
        req      = '0;
        req_data = '0;
        req_lock = '0;
        auto_tx  = 1'b0;
        man_busy = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_tx_load", 32'(tx_load), 0);
        chk("rst_arb_busy", 32'(arb_busy), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single requester with the busy fall aligned to a baud tick
        req_data[15:8] = 8'h41;
        req = 4'b0010;
        push(1, 8'h41);
        @(negedge clk);
        chk("t1_grant", 32'(grant), 32'h2);
        chk("t1_load", 32'(tx_load), 1);
        chk("t1_data", 32'(tx_data), 32'h41);
        chk("t1_owner", 32'(owner), 32'h2);
        chk("t1_busy", 32'(arb_busy), 1);
        @(negedge clk);
        req = '0;
        chk("t1_one_grant", 32'(grant), 0);
        chk("t1_one_load", 32'(tx_load), 0);
        man_busy = 1'b1;
        repeat (3) @(negedge clk);
        n = 0;
        @(posedge clk);
        while (!baud_tick && n < 20) begin
            @(posedge clk);
            n++;
        end
        repeat (7) @(posedge clk);
        @(negedge clk);
        man_busy = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        chk("t1_owner_hold", 32'(owner), 32'h2);
        @(posedge clk);
        #1;
        chk("t1_owner_clr", 32'(owner), 0);
        chk("t1_idle", 32'(arb_busy), 0);

        // Data change while the frame is in flight
        @(negedge clk);
        req_data[23:16] = 8'h5C;
        req = 4'b0100;
        push(2, 8'h5C);
        wait_load("t3_load");
        @(negedge clk);
        req = '0;
        man_busy = 1'b1;
        repeat (3) @(negedge clk);
        req_data[23:16] = 8'hFF;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (tx_load) n++;
        end
        chk("t3_no_reload", 32'(n), 0);
        chk("t3_data_held", 32'(tx_data), 32'h5C);
        man_busy = 1'b0;
        wait_idle("t3_idle");

        // Asynchronous reset in WAIT_DONE
        req_data[31:24] = 8'h3D;
        req = 4'b1000;
        push(3, 8'h3D);
        wait_load("t4_load");
        @(negedge clk);
        req = '0;
        man_busy = 1'b1;
        repeat (5) @(negedge clk);
        chk("t4_busy_pre", 32'(arb_busy), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t4_rst_grant", 32'(grant), 0);
        chk("t4_rst_owner", 32'(owner), 0);
        chk("t4_rst_data", 32'(tx_data), 0);
        chk("t4_rst_load", 32'(tx_load), 0);
        chk("t4_rst_busy", 32'(arb_busy), 0);
        @(negedge clk);
        man_busy = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        auto_tx = 1'b1;
        req_data[15:8]  = 8'h11;
        req_data[31:24] = 8'h33;
        req = 4'b1010;
        push(1, 8'h11);
        push(3, 8'h33);
        wait_load("t4_first");
        chk("t4_lowest", 32'(grant), 32'h2);
        @(negedge clk);
        req[1] = 1'b0;
        wait_load("t4_second");
        req = '0;
        wait_idle("t4_idle");

        // All four requesting continuously
        do_reset();
        req_data = 32'hA3A2A1A0;
        req = 4'b1111;
        push(0, 8'hA0);
        push(1, 8'hA1);
        push(2, 8'hA2);
        push(3, 8'hA3);
        push(0, 8'hA0);
        repeat (5) wait_load("t2_load");
        req = '0;
        wait_idle("t2_idle");

        // Locked requester 1 against pending requester 2
        do_reset();
        req_data[15:8]  = 8'hC1;
        req_data[23:16] = 8'hC2;
        req_lock = 4'b0010;
        req = 4'b0110;
`ifdef SERIAL_ARB_LOCK_EN
        nexp = 5;
        push(1, 8'hC1);
        push(1, 8'hC1);
        push(1, 8'hC1);
        push(1, 8'hC1);
        push(2, 8'hC2);
`else
        nexp = 4;
        push(1, 8'hC1);
        push(2, 8'hC2);
        push(1, 8'hC1);
        push(2, 8'hC2);
`endif
        repeat (nexp) wait_load("t5_load");
        req = '0;
        req_lock = '0;
        wait_idle("t5_idle");

        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
